// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, product type and default FIFO depth for the multiplier tile.
package mul_pkg;
    localparam int PROD_W = 16;
    localparam int BYTE_W = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/mul_fifo_store.sv
// mul_fifo_store: product storage array with head/tail pointers and entry count.
module mul_fifo_store
    import mul_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop_entry,
    input  product_t                 wr_data,
    output product_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    product_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign pop_ok  = pop_entry && !empty;
    // A freeing pop makes room for a push in the same cycle, even when full.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/mul_result_fifo.sv
// mul_result_fifo: buffers multiplier products for byte-serial host reads and keeps a running sum.
// Define MUL_ACC_SAT_EN for a saturating accumulator with a sticky acc_sat flag.
module mul_result_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int ACC_W = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  product_t                 in_data,
    input  logic                     clr,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        rd_byte,
    output logic                     rd_phase,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [ACC_W-1:0]         acc
`ifdef MUL_ACC_SAT_EN
    ,
    output logic                     acc_sat
`endif
);
    product_t     head;
    logic         pop_any;
    logic         freeing;
    logic [ACC_W:0] sum;

    assign pop_any = pop && !empty;
    assign freeing = pop_any && rd_phase;
    assign sum     = {1'b0, acc} + (ACC_W + 1)'(in_data);
    assign rd_byte = empty ? '0 : (rd_phase ? head[15:8] : head[7:0]);

    mul_fifo_store #(.DEPTH(DEPTH)) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (in_valid),
        .pop_entry (freeing),
        .wr_data   (in_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            rd_phase <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (pop_any) rd_phase <= !rd_phase;
            if (in_valid && full && !freeing) overflow <= 1'b1;
        end
    end

`ifdef MUL_ACC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (in_valid) begin
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            if (sum[ACC_W]) acc_sat <= 1'b1;
        end
    end
`else
    logic carry_unused;
    assign carry_unused = sum[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (in_valid) acc <= sum[ACC_W-1:0];
    end
`endif
endmodule

// File: tb/tb_mul_result_fifo.sv
// tb_mul_result_fifo: directed self-checking bench for mul_result_fifo (DEPTH=4, ACC_W=20).
module tb_mul_result_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        clr = 1'b0;
    logic        pop = 1'b0;
    logic [7:0]  rd_byte;
    logic        rd_phase;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        overflow;
    logic [19:0] acc;
`ifdef MUL_ACC_SAT_EN
    logic        acc_sat;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    mul_result_fifo #(.DEPTH(4), .ACC_W(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clr      (clr),
        .pop      (pop),
        .rd_byte  (rd_byte),
        .rd_phase (rd_phase),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .acc      (acc)
`ifdef MUL_ACC_SAT_EN
        ,
        .acc_sat  (acc_sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_bytes [8];
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_byte", rd_byte, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_phase", rd_phase, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_acc", acc, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single entry, byte-serial read
        push(16'h1234);
        chk("t1_lo", rd_byte, 8'h34);
        chk("t1_count", count, 1);
        do_pop();
        chk("t1_hi", rd_byte, 8'h12);
        chk("t1_phase", rd_phase, 1);
        chk("t1_count_kept", count, 1);
        do_pop();
        chk("t1_empty", empty, 1);
        chk("t1_rd0", rd_byte, 8'h00);
        chk("t1_phase0", rd_phase, 0);
        chk("t1_acc", acc, 20'h01234);

        // Fill, overflow, drain
        push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
        chk("t2_full", full, 1);
        chk("t2_count", count, 4);
        chk("t2_ovf0", overflow, 0);
        push(16'hBEEF);
        chk("t2_ovf", overflow, 1);
        chk("t2_count_ovf", count, 4);
        chk("t2_acc", acc, 20'h0D12D);
        exp_bytes = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_drain%0d", i), rd_byte, exp_bytes[i]);
            do_pop();
        end
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", overflow, 1);
        do_clr();
        chk("t2_clr_ovf", overflow, 0);
        chk("t2_clr_acc", acc, 0);

        // Push with freeing pop while full, pointer wrap
        push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
        do_pop();
        chk("t3_phase1", rd_phase, 1);
        in_valid = 1'b1; in_data = 16'h5555; pop = 1'b1;
        tick();
        in_valid = 1'b0; pop = 1'b0;
        chk("t3_count", count, 4);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow, 0);
        chk("t3_phase0", rd_phase, 0);
        exp_bytes = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h55, 8'h55};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_drain%0d", i), rd_byte, exp_bytes[i]);
            do_pop();
        end
        chk("t3_empty", empty, 1);

        // Pop while empty is ignored; push+pop while empty keeps the push
        do_pop();
        chk("t5_pop_empty_phase", rd_phase, 0);
        chk("t5_pop_empty_count", count, 0);
        in_valid = 1'b1; in_data = 16'hA55A; pop = 1'b1;
        tick();
        in_valid = 1'b0; pop = 1'b0;
        chk("t5_pushpop_count", count, 1);
        chk("t5_pushpop_phase", rd_phase, 0);
        chk("t5_pushpop_byte", rd_byte, 8'h5A);

        // clr beats push and pop in the same cycle
        push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
        chk("t5_ovf_set", overflow, 1);
        do_pop();
        clr = 1'b1; in_valid = 1'b1; in_data = 16'h7777; pop = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0; pop = 1'b0;
        chk("t5_clr_count", count, 0);
        chk("t5_clr_empty", empty, 1);
        chk("t5_clr_acc", acc, 0);
        chk("t5_clr_ovf", overflow, 0);
        chk("t5_clr_phase", rd_phase, 0);
        tick();
        chk("t5_nothing_stored", count, 0);
        chk("t5_rd0", rd_byte, 8'h00);

        // Accumulator carry-out
        for (int i = 0; i < 16; i++) push(16'hFFFF);
        chk("t4_acc16", acc, 20'hFFFF0);
`ifdef MUL_ACC_SAT_EN
        chk("t4_sat0", acc_sat, 0);
        push(16'hFFFF);
        chk("t4_acc17", acc, 20'hFFFFF);
        chk("t4_sat1", acc_sat, 1);
`else
        push(16'hFFFF);
        chk("t4_acc17", acc, 20'h0FFEF);
`endif
        do_clr();
        chk("t4_clr_acc", acc, 0);

        // Asynchronous reset mid-cycle
        push(16'hA1B2); push(16'hC3D4); push(16'hE5F6);
        do_pop();
        chk("t6_count", count, 3);
        chk("t6_hi", rd_byte, 8'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_empty", empty, 1);
        chk("t6_async_count", count, 0);
        chk("t6_async_phase", rd_phase, 0);
        chk("t6_async_byte", rd_byte, 8'h00);
        chk("t6_async_acc", acc, 0);
        in_valid = 1'b1; in_data = 16'h1111;
        tick();
        in_valid = 1'b0;
        chk("t6_lost_push", count, 0);
        chk("t6_lost_acc", acc, 0);
        rst_n = 1'b1;
        tick();
        chk("t6_after_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_result_fifo.md
Name: mul_result_fifo

Overview:
Downstream consumer of the 8x8 shift-add multiplier core. It captures each 16-bit product on the core's one-cycle done pulse into a small FIFO and maintains a running sum of all products. The host drains results byte-serially (low byte, then high byte) through the tile's 8-bit output bus, so back-to-back multiplies are not lost while the host is slow to read.

Parameters:
DEPTH, 4, number of 16-bit product entries; power of two, 2..8.
ACC_W, 20, running-sum width in bits; must be at least 16.

Ports:
clk  input  1  clock; single clock domain.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  product strobe; connects to the core's done (1-cycle pulse).
in_data  input  16  product; sampled only when in_valid=1.
clr  input  1  synchronous clear of FIFO, flags and accumulator.
pop  input  1  1-cycle pulse; advances the read byte.
rd_byte  output  8  current read byte; combinational from head entry and phase.
rd_phase  output  1  0 = low byte presented, 1 = high byte presented.
empty  output  1  FIFO holds no entries.
full  output  1  FIFO holds DEPTH entries.
count  output  $clog2(DEPTH)+1  number of entries held.
overflow  output  1  sticky; a push was dropped.
acc  output  ACC_W  running sum of every in_valid product.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, count=0, rd_phase=0, overflow=0, acc=0, storage contents don't-care.
- Resulting output values after reset: empty=1, full=0, rd_byte=0x00.
- Push: in_valid=1 and (not full, or a freeing pop in the same cycle) -> in_data written at tail; count increments one cycle later. No pass-through: rd_byte reflects a new entry the cycle after the push.
- Pop, phase 0: rd_phase goes to 1; entry is retained.
- Pop, phase 1 (freeing pop): head advances, count decrements, rd_phase goes to 0.
- Pop while empty: ignored; no state change.
- rd_byte = head[7:0] when rd_phase=0, head[15:8] when rd_phase=1, 0x00 when empty.
- Simultaneous push and freeing pop: both take effect; count unchanged. This is legal even when full.
- Push while full without a freeing pop: data dropped, overflow set to 1 and held until clr or reset. acc still adds the product.
- Push while empty plus a pop in the same cycle: the pop is ignored and the push succeeds.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Accumulator: on every in_valid, acc <= acc + zero-extend(in_data), independent of FIFO acceptance.
- Width rule: the sum is computed at ACC_W+1 bits; the carry-out is handled per the optional feature.
- clr has priority over push and pop in the same cycle. Effect: count=0, rd_phase=0, overflow=0, acc=0, and the same-cycle in_valid is discarded.
- Reset mid-operation: all state returns to reset values immediately. A done pulse coinciding with reset is lost.
- No internal FSM beyond the rd_phase bit and the pointer/count registers; all state updates on the rising edge of clk.

Optional Feature:
Macro: MUL_ACC_SAT_EN.
- Defined: acc saturates at 2^ACC_W-1, and an extra output acc_sat (1 bit, sticky, cleared by clr/reset) is set when saturation occurs.
- Undefined: acc wraps modulo 2^ACC_W, and the acc_sat port is absent.

Decomposition:
Shared package mul_pkg holds:
- PROD_W=16, BYTE_W=8.
- The product_t typedef (logic [15:0]), also reused by the multiplier wrapper.
- A default FIFO depth constant.

One sub-module, mul_fifo_store, is natural: it holds the storage array plus head/tail/count logic, with push/pop_entry handshake and full/empty outputs. The top level adds the byte-phase logic, overflow flag and accumulator.

Test Plan:
1. Reset release, then push 0x1234 -> next cycle rd_byte=0x34, count=1. Pop -> rd_byte=0x12, rd_phase=1. Pop -> empty=1, rd_byte=0x00.
2. Push 0x0001, 0x0002, 0x0003, 0x0004 (DEPTH=4) -> full=1, count=4. Push 0xBEEF -> overflow=1, count=4. Drain 8 pops yields bytes 01,00,02,00,03,00,04,00.
3. Full FIFO, rd_phase=1, push 0x5555 in the same cycle as pop -> count stays 4, overflow stays 0, 0x5555 emerges last.
4. ACC_W=20, 16 pushes of 0xFFFF -> acc=0xFFFF0. 17th push:
   - with MUL_ACC_SAT_EN: acc=0xFFFFF, acc_sat=1.
   - without: acc=0x0FFEF.
5. Pop while empty -> no change. clr asserted together with in_valid=1 and pop=1 -> count=0, acc=0, overflow=0, nothing stored.
6. Assert rst_n=0 asynchronously between clock edges with 3 entries held and rd_phase=1 -> outputs immediately reach reset values, without waiting for a clock edge.
